// File: rtl/encode_pkg.sv
// encode_pkg: shared constants and helpers for the Kyber ByteEncode_l packer.
//   N      coefficients per polynomial
//   CW     coefficient width
//   OW     output word width
//   BUF_W  bit-buffer capacity (63 residual bits + one 24-bit pair fits)
//   DBG_W  width of the full packed-image register (N*CW bits = 384 bytes)
package encode_pkg;

  localparam int N     = 256;
  localparam int CW    = 12;
  localparam int OW    = 64;
  localparam int PAIRS = N / 2;
  localparam int BUF_W = 88;
  localparam int DBG_W = N * CW;

  // l values used by Kyber (bit k set means l=k is used): 1,4,5,10,11,12
  localparam logic [12:0] L_KYBER = 13'b1_1100_0011_0010;

  // Out-of-range widths fall back to full 12-bit packing.
  function automatic logic [3:0] eff_l(input logic [3:0] l);
    return ((l == 4'd0) || (l > 4'd12)) ? 4'd12 : l;
  endfunction

  // Stream byte q (LSB-first) goes to the q-th most significant byte lane.
  function automatic logic [OW-1:0] byte_rev(input logic [OW-1:0] w);
    logic [OW-1:0] r;
    r = '0;
    for (int q = 0; q < OW / 8; q++) begin
      r[OW-1-8*q -: 8] = w[8*q +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/encode_bitbuf.sv
// encode_bitbuf: LSB-first bit accumulator with variable-width append and a
// fixed 64-bit pop.
//   i_clk, i_rstn  clock / async active-low reset
//   i_push         append i_len bits of i_bits this cycle
//   i_bits         bits to append, oldest at bit 0, zero above i_len
//   i_len          number of bits to append (0..24)
//   o_pop          the current edge removes the oldest 64 bits
//   o_word         those 64 bits, stream order (bit 0 oldest)
module encode_bitbuf
  import encode_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_push,
  input  logic [2*CW-1:0] i_bits,
  input  logic [4:0]      i_len,
  output logic            o_pop,
  output logic [OW-1:0]   o_word
);

  logic [BUF_W-1:0] bits_q, bits_d, merged;
  logic [6:0]       cnt_q, cnt_d, cnt_sum;

  // The pop is decided on the merged contents so a word completed by the
  // current pair leaves on this same edge; the buffer never holds 64+ bits.
  always_comb begin
    merged  = bits_q;
    cnt_sum = cnt_q;
    if (i_push) begin
      merged  = bits_q | ({{(BUF_W-2*CW){1'b0}}, i_bits} << cnt_q);
      cnt_sum = cnt_q + {2'b00, i_len};
    end
    o_pop  = (cnt_sum >= 7'd64);
    o_word = merged[OW-1:0];
    bits_d = merged;
    cnt_d  = cnt_sum;
    if (o_pop) begin
      bits_d = merged >> OW;
      cnt_d  = cnt_sum - 7'd64;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      bits_q <= '0;
      cnt_q  <= '0;
    end else begin
      bits_q <= bits_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/encode.sv
// encode: Kyber ByteEncode_l packer. Takes 128 coefficient pairs per frame,
// keeps the low l bits of each, packs them little-endian and emits 64-bit
// words with stream byte 0 in the MSB lane.
//   i_clk, i_rstn    clock / async active-low reset
//   i_coeffs         [23:12] coeff 2j, [11:0] coeff 2j+1
//   i_coeffs_valid   pair valid (no backpressure)
//   i_l              bits per coefficient, sampled on pair 0
//   o_obytes         packed word, held while o_obytes_valid=0
//   o_obytes_valid   new word this cycle
//   o_done           pulse with the last word of the frame
// o_obytes_debug holds the whole packed polynomial, B[0] at the top of the
// 256*l-bit image, for hierarchical inspection.
module encode
  import encode_pkg::*;
(
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic [2*CW-1:0] i_coeffs,
  input  logic            i_coeffs_valid,
  input  logic [3:0]      i_l,
  output logic [OW-1:0]   o_obytes,
  output logic            o_obytes_valid,
  output logic            o_done
);

  logic [6:0]       pair_q, pair_d;
  logic [3:0]       l_q, l_d, l_cur;
  logic [OW-1:0]    obytes_q, obytes_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;
  logic [DBG_W-1:0] o_obytes_debug, o_obytes_debug_d;

  logic             first;
  logic [CW-1:0]    mask;
  logic [2*CW-1:0]  pair_bits;
  logic             pop;
  logic [OW-1:0]    word, word_be;

  encode_bitbuf u_bitbuf (
    .i_clk  (i_clk),
    .i_rstn (i_rstn),
    .i_push (i_coeffs_valid),
    .i_bits (pair_bits),
    .i_len  ({l_cur, 1'b0}),
    .o_pop  (pop),
    .o_word (word)
  );

  assign word_be = byte_rev(word);

  always_comb begin
    first = i_coeffs_valid && (pair_q == 7'd0);
    // Pair 0 packs with the width it carries, before the latch updates.
    l_cur = first ? eff_l(i_l) : l_q;
    mask  = CW'((13'h1 << l_cur) - 13'h1);
    pair_bits = {{CW{1'b0}}, i_coeffs[2*CW-1:CW] & mask}
              | ({{CW{1'b0}}, i_coeffs[CW-1:0] & mask} << l_cur);

    pair_d   = i_coeffs_valid ? pair_q + 7'd1 : pair_q;
    l_d      = first ? eff_l(i_l) : l_q;
    obytes_d = pop ? word_be : obytes_q;
    valid_d  = pop;
    // The final pair always completes the final word (256*l is a multiple of 64).
    done_d   = i_coeffs_valid && (pair_q == 7'(PAIRS - 1));

    // Words shift in at the bottom, so after 4l words B[0] sits at bit
    // 256*l-1 and everything above stays zero. The clear on pair 0 lands on
    // the edge after o_done, so the reported image is intact in that cycle.
    o_obytes_debug_d = o_obytes_debug;
    if (first) begin
      o_obytes_debug_d = '0;
    end else if (pop) begin
      o_obytes_debug_d = {o_obytes_debug[DBG_W-OW-1:0], word_be};
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      pair_q         <= '0;
      l_q            <= 4'd12;
      obytes_q       <= '0;
      valid_q        <= 1'b0;
      done_q         <= 1'b0;
      o_obytes_debug <= '0;
    end else begin
      pair_q         <= pair_d;
      l_q            <= l_d;
      obytes_q       <= obytes_d;
      valid_q        <= valid_d;
      done_q         <= done_d;
      o_obytes_debug <= o_obytes_debug_d;
    end
  end

  assign o_obytes       = obytes_q;
  assign o_obytes_valid = valid_q;
  assign o_done         = done_q;

endmodule

// File: tb/tb_encode.sv
module tb_encode;

  logic        i_clk;
  logic        i_rstn;
  logic [23:0] i_coeffs;
  logic        i_coeffs_valid;
  logic [3:0]  i_l;
  logic [63:0] o_obytes;
  logic        o_obytes_valid;
  logic        o_done;

  encode dut (
    .i_clk          (i_clk),
    .i_rstn         (i_rstn),
    .i_coeffs       (i_coeffs),
    .i_coeffs_valid (i_coeffs_valid),
    .i_l            (i_l),
    .o_obytes       (o_obytes),
    .o_obytes_valid (o_obytes_valid),
    .o_done         (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [63:0] w;
    bit          done;
    int          gap;
    bit          first;
  } exp_t;

  exp_t          exq[$];
  logic [3071:0] dbq[$];
  int            tests = 0;
  int            fails = 0;
  int            exp_frames = 0;
  int            done_cnt = 0;
  logic [63:0]   first_word = '0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_dbg(input logic [3071:0] act, input logic [3071:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      for (int k = 47; k >= 0; k--) begin
        if (act[64*k +: 64] !== exp[64*k +: 64]) begin
          $display("FAIL debug_image chunk %0d: got %h want %h", k, act[64*k +: 64], exp[64*k +: 64]);
          break;
        end
      end
    end
  endtask

  // Reference: build the FIPS 203 bit stream b[i*l+k] = bit k of coeff i,
  // cut it into bytes, then into words of 8 bytes (byte 0 in the MSB lane).
  task automatic model_push(input int l, input int np, input logic [11:0] c [256], input bit chk_gap);
    bit            bq[$];
    logic [7:0]    by[$];
    logic [7:0]    b;
    logic [3071:0] img;
    exp_t          e;
    int            nw;
    for (int i = 0; i < 2 * np; i++)
      for (int k = 0; k < l; k++) bq.push_back(c[i][k]);
    nw = bq.size() / 64;
    for (int n = 0; n < nw * 8; n++) begin
      b = '0;
      for (int t = 0; t < 8; t++) b[t] = bq[8*n+t];
      by.push_back(b);
    end
    for (int m = 0; m < nw; m++) begin
      e.w = '0;
      for (int q = 0; q < 8; q++) e.w[63-8*q -: 8] = by[8*m+q];
      e.done  = (np == 128) && (m == nw - 1);
      e.gap   = (chk_gap && m > 0) ? 32 : 0;
      e.first = (m == 0);
      exq.push_back(e);
    end
    if (np == 128) begin
      img = '0;
      for (int n = 0; n < 32 * l; n++) img[256*l-1-8*n -: 8] = by[n];
      dbq.push_back(img);
      exp_frames++;
    end
  endtask

  // Monitor / scoreboard
  initial begin
    int          cyc;
    int          last_cyc;
    logic [63:0] last_word;
    exp_t        e;
    cyc = 0; last_cyc = 0; last_word = '0;
    forever begin
      @(negedge i_clk);
      cyc++;
      if (!i_rstn) begin
        last_word = '0;
        continue;
      end
      if (o_obytes_valid) begin
        if (exq.size() == 0) begin
          check("unexpected_word", o_obytes, 64'h0);
          tests++; fails++;
          $display("FAIL unexpected_word: got %h want none", o_obytes);
        end else begin
          e = exq.pop_front();
          check("word", o_obytes, e.w);
          check("done_with_word", {63'b0, o_done}, {63'b0, e.done});
          if (e.gap != 0) check("word_gap", 64'(cyc - last_cyc), 64'(e.gap));
          if (e.first) first_word = o_obytes;
        end
        last_cyc  = cyc;
        last_word = o_obytes;
      end else begin
        check("word_hold", o_obytes, last_word);
        check("done_without_valid", {63'b0, o_done}, 64'h0);
      end
      if (o_done) begin
        done_cnt++;
        if (dbq.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got done want none");
        end else begin
          check_dbg(dut.o_obytes_debug, dbq.pop_front());
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish within bound");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "timeout");
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk); #1;
      i_coeffs_valid = 1'b0;
      i_l = 4'($urandom_range(0, 15));
    end
  endtask

  // pat: 0 random, 1 coeff=i, 2 all 0xFFF, 3 coeff = i mod 16
  task automatic send_frame(input int lraw, input int pat, input int gap_pct, input int np);
    logic [11:0] c [256];
    int l;
    l = (lraw == 0 || lraw > 12) ? 12 : lraw;
    for (int i = 0; i < 256; i++) begin
      case (pat)
        1:       c[i] = 12'(i);
        2:       c[i] = 12'hFFF;
        3:       c[i] = 12'(i % 16);
        default: c[i] = 12'($urandom_range(0, 4095));
      endcase
    end
    model_push(l, np, c, (l == 1) && (gap_pct == 0));
    for (int j = 0; j < np; j++) begin
      if (j > 0) begin
        while ((gap_pct != 0) && ($urandom_range(0, 99) < gap_pct)) begin
          @(posedge i_clk); #1;
          i_coeffs_valid = 1'b0;
          i_coeffs = 24'($urandom);
        end
      end
      @(posedge i_clk); #1;
      i_coeffs_valid = 1'b1;
      i_coeffs = {c[2*j], c[2*j+1]};
      i_l = (j == 0) ? 4'(lraw) : 4'($urandom_range(0, 15));
    end
  endtask

  initial begin
    i_rstn = 1'b0;
    i_coeffs = '0;
    i_coeffs_valid = 1'b0;
    i_l = 4'd0;
    repeat (3) @(posedge i_clk);
    #1;
    check("rst_obytes", o_obytes, 64'h0);
    check("rst_valid", {63'b0, o_obytes_valid}, 64'h0);
    check("rst_done", {63'b0, o_done}, 64'h0);
    tests++;
    if (dut.o_obytes_debug !== '0) begin
      fails++;
      $display("FAIL rst_debug: got nonzero want 0");
    end
    i_rstn = 1'b1;
    idle(2);

    send_frame(12, 1, 0, 128);
    idle(4);
    check("l12_first_word", first_word, 64'h0010000230000450);

    send_frame(1, 2, 0, 128);
    idle(4);
    check("l1_first_word", first_word, 64'hFFFFFFFFFFFFFFFF);

    send_frame(4, 3, 0, 128);
    idle(4);
    check("l4_first_word", first_word, 64'h1032547698BADCFE);

    send_frame(10, 0, 0, 128);
    send_frame(11, 0, 0, 128);
    send_frame(0, 0, 10, 128);
    send_frame(13, 0, 0, 128);
    idle(3);

    send_frame(5, 0, 25, 128);
    send_frame(12, 0, 25, 128);
    idle(4);

    // Abort mid-frame: only words completed before the reset appear.
    send_frame(10, 0, 0, 60);
    idle(3);
    i_rstn = 1'b0;
    idle(3);
    check("abort_words_drained", 64'(exq.size()), 64'h0);
    check("abort_done_count", 64'(done_cnt), 64'(exp_frames));
    i_rstn = 1'b1;
    idle(2);
    send_frame(11, 0, 0, 128);
    idle(4);

    for (int w = 0; w < 200 && exq.size() != 0; w++) idle(1);
    check("words_left", 64'(exq.size()), 64'h0);
    check("debug_left", 64'(dbq.size()), 64'h0);
    check("done_count", 64'(done_cnt), 64'(exp_frames));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/encode.md
Name: encode

Overview:
- Kyber ByteEncode_l packer, used on the compression/serialisation path.
- Accepts 256 coefficients, two per cycle over 128 input cycles.
- Keeps the low l bits of each coefficient, packs them little-endian into a bit stream, and emits the stream as 64-bit words.
- Also keeps the complete packed polynomial (up to 384 bytes) in an internal register for bench checking.

Parameters:
- N, 256, coefficients per polynomial.
- CW, 12, coefficient width.
- OW, 64, output word width.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rstn  input  1  asynchronous active-low reset.
- i_coeffs  input  24  coefficient pair: [23:12] is coeff 2j, [11:0] is coeff 2j+1.
- i_coeffs_valid  input  1  pair valid this cycle; no backpressure.
- i_l  input  4  bits per coefficient; legal 1..12 (Kyber uses 1,4,5,10,11,12).
- o_obytes  output  64  packed output word.
- o_obytes_valid  output  1  o_obytes holds a new word.
- o_done  output  1  one-cycle pulse at end of polynomial.
- o_obytes_debug  internal reg  3072  full packed result; readable hierarchically, not a port.

Behaviour:
- Clock and reset: one clock (i_clk); reset is asynchronous and active-low (i_rstn).
- Reset state: all outputs 0, pair counter 0, bit buffer empty, o_obytes_debug 0.
- Frame definition:
  - A frame is 128 accepted pairs (j = 0..127), counted by a 7-bit counter.
  - i_l is latched on pair j=0 and held for the frame.
  - i_l values 0 or greater than 12 are treated as 12.
  - Gaps in i_coeffs_valid are allowed mid-frame.
- Bit stream (FIPS 203): stream bit b[i*l+k] = bit k of coeff i, for k < l; upper coeff bits are ignored.
- Byte formation: byte B[n] = sum over t of b[8n+t]*2^t (LSB first); a frame yields 32*l bytes.
- Buffering:
  - Each accepted pair appends 2l bits to a bit buffer of at least 88 bits.
  - Whenever the buffer holds at least 64 bits, the oldest 64 are emitted on the next clock edge with o_obytes_valid=1.
  - Word byte order: B[8m+q] is placed at o_obytes[63-8q -: 8]; B[8m] is the MSB byte.
  - 4*l words per frame.
  - Because 256*l is a multiple of 64, the buffer is exactly empty at frame end.
- Latency: a word is valid in the cycle after the pair that completes it is sampled.
- o_obytes holds its last value while o_obytes_valid=0.
- o_done is asserted in the same cycle as the final (4l-th) word's valid, for exactly one cycle.
- o_obytes_debug:
  - Cleared when pair j=0 of a new frame is accepted.
  - Byte B[n] is written at bits [256*l-1-8n -: 8].
  - Bits at 256*l and above stay 0.
  - Valid from the o_done cycle until the next frame's first pair.
- i_coeffs_valid during the o_done cycle: accepted as pair 0 of the next frame; the debug clear must not corrupt the value being reported by o_done in that cycle.
- Reset mid-frame: frame is aborted, buffer and counters flush, and no o_done is issued.

Decomposition:
- Shared package holds the constants N=256, CW=12, OW=64 and the legal-l list.
- One sub-module is natural: encode_bitbuf, a variable-width append (2l bits) with a fixed 64-bit pop.
- Counters, i_l latch and debug image stay in encode.

Test Plan:
- l=12, coeff i = i → 48 words and one o_done; B[0]=0x00, B[1]=0x10, B[2]=0x00 (coeffs 0 and 1); debug upper 0 bits unused.
- l=1, all coeffs = 0xFFF → 4 words, each 0xFFFFFFFFFFFFFFFF; word gaps of 32 cycles; debug bits [255:0] all 1, rest 0.
- l=4, coeff i = i mod 16 → 16 words; B[0]=0x10, B[1]=0x32; first word 0x1032547698BADCFE.
- l=10 and l=11 random vectors → 40 and 44 words respectively; debug equals the reference ByteEncode image; o_done pulses once per frame.
- Back-to-back frames l=5 then l=12, with valid gaps inserted mid-frame → correct word counts (20 and 48); debug cleared between frames.
- Assert i_rstn low at pair 60 → no o_done for that frame; the following full frame encodes correctly.
